// File: rtl/adr_gen_nested_if.sv
// Bundles the config and stepping handshake between the accelerator controller
// and the nested-loop address generator.
interface adr_gen_nested_if #(
  parameter int BANK_ADDR_WIDTH = 8
);
  logic                       config_en;
  logic [BANK_ADDR_WIDTH-1:0] config_data;
  logic                       adr_en;
  logic [BANK_ADDR_WIDTH-1:0] adr;
  logic                       last;

  modport master (
    output config_en,
    output config_data,
    output adr_en,
    input  adr,
    input  last
  );

  modport slave (
    input  config_en,
    input  config_data,
    input  adr_en,
    output adr,
    output last
  );
endinterface

// File: rtl/adr_gen_nested.sv
// Nested-loop strided address generator: walks NUM_LOOPS odometer-ordered loops
// and emits base + sum(idx[i]*stride[i]) per step, configured by a serial word burst.
module adr_gen_nested #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int NUM_LOOPS       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  adr_gen_nested_if.slave  bus
);
  localparam int W         = BANK_ADDR_WIDTH;
  localparam int NUM_WORDS = 2 * NUM_LOOPS + 1;
  localparam int CW        = $clog2(NUM_WORDS + 1);

  logic [W-1:0]  base;
  logic [W-1:0]  bound   [NUM_LOOPS];
  logic [W-1:0]  stride  [NUM_LOOPS];
  logic [W-1:0]  idx     [NUM_LOOPS];
  logic [W-1:0]  idx_nxt [NUM_LOOPS];
  logic [CW-1:0] cfg_cnt;
  logic          carry;
  logic [W-1:0]  adr_acc;
  logic          all_last;

  // Odometer increment; a carry out of the outermost loop leaves every index at 0.
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      idx_nxt[i] = idx[i];
      if (carry) begin
        if (idx[i] == bound[i]) begin
          idx_nxt[i] = '0;
        end else begin
          idx_nxt[i] = idx[i] + 1'b1;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    adr_acc  = base;
    all_last = 1'b1;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      adr_acc  = adr_acc + W'(idx[i] * stride[i]);
      all_last = all_last & (idx[i] == bound[i]);
    end
  end

  assign bus.adr  = adr_acc;
  assign bus.last = all_last;

  // cfg_cnt saturates at NUM_WORDS so extra words in a long burst write nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      cfg_cnt <= '0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        bound[i]  <= '0;
        stride[i] <= '0;
        idx[i]    <= '0;
      end
    end else if (bus.config_en) begin
      if (cfg_cnt != CW'(NUM_WORDS)) begin
        cfg_cnt <= cfg_cnt + 1'b1;
      end
      if (cfg_cnt == '0) begin
        base <= bus.config_data;
      end
      for (int i = 0; i < NUM_LOOPS; i++) begin
        idx[i] <= '0;
        if (cfg_cnt == CW'(2 * i + 1)) begin
          bound[i] <= bus.config_data;
        end
        if (cfg_cnt == CW'(2 * i + 2)) begin
          stride[i] <= bus.config_data;
        end
      end
    end else begin
      cfg_cnt <= '0;
      if (bus.adr_en) begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
          idx[i] <= idx_nxt[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_adr_gen_nested.sv
// Directed bench for adr_gen_nested: table of {config_en, config_data, adr_en, expected adr/last}
// plus hand sequences for the long single loop and async reset mid-burst.
module tb_adr_gen_nested;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  adr_gen_nested_if #(.BANK_ADDR_WIDTH(8)) bus ();

  adr_gen_nested #(
    .BANK_ADDR_WIDTH(8),
    .NUM_LOOPS      (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cfg_en;
    logic [7:0] cfg_data;
    logic       adr_en;
    logic [7:0] exp_adr;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ce, input logic [7:0] d, input logic ae,
                              input logic [7:0] ea, input logic el);
    vec_t v;
    v.cfg_en   = ce;
    v.cfg_data = d;
    v.adr_en   = ae;
    v.exp_adr  = ea;
    v.exp_last = el;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input logic ce, input logic [7:0] d, input logic ae);
    bus.config_en   = ce;
    bus.config_data = d;
    bus.adr_en      = ae;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ea, input logic el);
    n_vec++;
    if (bus.adr !== ea || bus.last !== el) begin
      n_err++;
      $display("[TB] FAIL %s: adr=%0d last=%0b, required adr=%0d last=%0b",
               name, bus.adr, bus.last, ea, el);
    end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    bus.config_en   = 1'b0;
    bus.config_data = '0;
    bus.adr_en      = 1'b0;
    #12;
    checkOutput("reset", 8'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state: all bounds 0, stepping keeps adr at base 0.
    add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
    // 2D tile: base=10, b0=2 s0=1, b1=1 s1=8, b2=0 s2=0.
    add(1, 10, 0, 10, 1); add(1, 2, 0, 10, 0); add(1, 1, 0, 10, 0); add(1, 1, 0, 10, 0);
    add(1, 8, 0, 10, 0);  add(1, 0, 0, 10, 0); add(1, 0, 0, 10, 0);
    add(0, 0, 1, 11, 0); add(0, 0, 1, 12, 0); add(0, 0, 1, 18, 0); add(0, 0, 1, 19, 0);
    add(0, 0, 1, 20, 1); add(0, 0, 1, 10, 0); add(0, 0, 1, 11, 0); add(0, 0, 1, 12, 0);
    add(0, 0, 1, 18, 0);
    // One-word burst with adr_en also high: only base changes, idx cleared.
    add(1, 40, 1, 40, 0);
    add(0, 0, 1, 41, 0); add(0, 0, 1, 42, 0); add(0, 0, 1, 48, 0); add(0, 0, 1, 49, 0);
    add(0, 0, 1, 50, 1); add(0, 0, 1, 40, 0);
    // Modulo wrap: base=250, b0=3 s0=3, rest 0, plus an ignored 8th word.
    add(1, 250, 0, 250, 0); add(1, 3, 0, 250, 0); add(1, 3, 0, 250, 0); add(1, 0, 0, 250, 0);
    add(1, 0, 0, 250, 0);   add(1, 0, 0, 250, 0); add(1, 0, 0, 250, 0); add(1, 99, 0, 250, 0);
    add(0, 0, 1, 253, 0); add(0, 0, 0, 253, 0); add(0, 0, 1, 0, 0); add(0, 0, 1, 3, 1);
    add(0, 0, 1, 250, 0); add(0, 0, 1, 253, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cfg_en, vecs[i].cfg_data, vecs[i].adr_en);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_adr, vecs[i].exp_last);
    end

    // Single loop 0..49 with unit stride.
    applyStimulus(1, 0, 0);  checkOutput("s1_base", 0, 0);
    applyStimulus(1, 49, 0); checkOutput("s1_b0", 0, 0);
    applyStimulus(1, 1, 0);  checkOutput("s1_s0", 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0);
      checkOutput($sformatf("s1_w%0d", k + 3), 0, 0);
    end
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("s1_step%0d", k), 8'(k % 50), (k % 50) == 49);
    end
    applyStimulus(0, 0, 0); checkOutput("s1_hold", 0, 0);
    applyStimulus(0, 0, 1); checkOutput("s1_after_hold", 1, 0);

    // Async reset in the middle of a burst, then a short burst proves bounds were cleared.
    applyStimulus(1, 77, 0); checkOutput("rb_w0", 77, 0);
    bus.config_data = 8'd9;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("rb_async", 0, 1);
    @(negedge clk);
    bus.config_en = 1'b0;
    rst_n         = 1'b1;
    applyStimulus(1, 5, 0); checkOutput("rb_base5", 5, 1);
    applyStimulus(0, 0, 1); checkOutput("rb_step1", 5, 1);
    applyStimulus(0, 0, 1); checkOutput("rb_step2", 5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
